gpsdo_uart_tx: RTL and testbench
================================

# gpsdo_uart_tx

Serial transmitter on the receiving end of the phase detector's `Uart_En`/`Uart_Data`/`Uart_Busy` byte interface. It drives 8N1 frames (optionally 8E1) onto the board UART pin, so each phase-error byte reaches the host logger.
- Captures one byte on each rising edge of `Uart_En`.
- Because the detector holds `Uart_En` high for many cycles, the level is never re-triggered; one edge sends exactly one frame.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 115200, line rate in bit/s.
- `CLK_SYS` input 1: system clock; all logic on the rising edge.
- `CLK_RST` input 1: asynchronous, active-low reset.
- `Uart_En` input 1: send request; only a 0→1 transition between consecutive samples is a request.
- `Uart_Data` input 8: byte to send; sampled on the request cycle only.
- `Uart_Busy` output 1: high while a frame is in progress.
- `Uart_Tx` output 1: serial line; idles high.
- `Uart_Done` output 1: one-cycle pulse when a stop bit completes.
- `Uart_Ovf` output 1: one-cycle pulse when a request is dropped because a frame is in progress.

## Operation
- Bit period:
  - `BAUD_DIV = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE`, integer, computed at elaboration.
  - Default is 434.
  - Divider counter is 16 bits wide and counts 0..`BAUD_DIV`-1.
  - `BAUD_DIV` < 2 is a configuration error; flag it with an elaboration-time check.
- Edge detect:
  - Register `en_d` holds the previous `Uart_En`; it resets to 0.
  - A request is `Uart_En & ~en_d`.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
  - IDLE: when a request arrives, latch `Uart_Data` into the shift register, clear the divider, clear the bit index, and go to START. Otherwise stay.
  - START: `Uart_Tx`=0 for `BAUD_DIV` cycles, then go to DATA.
  - DATA: send the shift register LSB first, one bit per period, bit index 0..7. After bit 7, go to PARITY if enabled, else STOP.
  - PARITY: send `^data` (even parity) for one period, then go to STOP.
  - STOP: `Uart_Tx`=1 for one period, then pulse `Uart_Done` and go to IDLE.
- `Uart_Busy` = (state != IDLE), registered.
- A request that arrives while state != IDLE is discarded and pulses `Uart_Ovf`. The in-flight frame is not disturbed.
- Changes to `Uart_Data` outside the request cycle have no effect.
- Reset values:
  - `Uart_Tx`=1, `Uart_Busy`=0, `Uart_Done`=0, `Uart_Ovf`=0.
  - State IDLE, `en_d`=0, counters 0.
- Reset mid-frame: the frame is abandoned and `Uart_Tx` returns high immediately (asynchronous). No `Uart_Done` pulse.
- `Uart_En` already high when reset releases: `en_d`=0, so this counts as a request and one frame is sent.

## Timing
- Request sampled at clock edge N:
  - At edge N, `Uart_Tx` falls and `Uart_Busy` rises. All outputs are registered, so there is no combinational path from inputs.
- Start bit covers edges N..N+D-1, where D=`BAUD_DIV`. Data bit k covers N+(k+1)·D..N+(k+2)·D-1.
- Stop bit ends at edge N+10·D (N+11·D with parity). At that edge:
  - `Uart_Busy` falls.
  - `Uart_Done` is high for exactly that cycle.
- A request at edge N+10·D is in IDLE, so it is accepted. Gapless back-to-back frames are possible.
- A request at any edge N+1..N+10·D-1 is dropped, with `Uart_Ovf` high at the following cycle only.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is compiled in and frames are 8E1, 11 bit periods.
  - Parity bit = XOR of the 8 data bits (even parity).
- Not defined:
  - 8N1, 10 bit periods.
  - The PARITY state and its logic are absent.

## Test plan
All scenarios use `CLK_FREQ`=1_000_000 and `BAUD_RATE`=100_000, giving D=10.
- Reset, then one-cycle pulse on `Uart_En` with `Uart_Data`=0x55:
  - `Uart_Tx` reads 0,1,0,1,0,1,0,1,0,1 at the middle of each 10-cycle period.
  - `Uart_Busy` is high for exactly 100 cycles.
  - `Uart_Done` pulses once at cycle 100.
- `Uart_En` held high for 5000 cycles with `Uart_Data`=0xA3: exactly one frame, LSB-first bits 1,1,0,0,0,1,0,1; `Uart_Ovf` never asserts.
- Second rising edge (data 0x12) 40 cycles into a frame of 0x0F: `Uart_Ovf` pulses once, the 0x0F frame completes unchanged, and 0x12 is never sent.
- Second request (0xFF) in the same cycle `Uart_Done` pulses for a 0x00 frame:
  - The next start bit begins immediately; there is no idle cycle on `Uart_Tx`.
  - `Uart_Busy` stays high.
- `CLK_RST` asserted at cycle 35 of a frame: `Uart_Tx`=1 and `Uart_Busy`=0 at once; no `Uart_Done`; the next request sends a clean frame.
- With `UART_TX_PARITY_EN`: frames for 0x07 and 0x03 are 110 cycles long, with parity bit 1 for 0x07 and 0 for 0x03.

Source files
------------

// File: rtl/gpsdo_uart_tx_if.sv
// gpsdo_uart_tx_if
//   Byte hand-off between the phase detector and the UART transmitter.
//   master : phase detector side (drives Uart_En/Uart_Data, observes status)
//   slave  : transmitter side (samples request, drives line and status)
//   Uart_En   : send request, rising edge only
//   Uart_Data : byte to send, sampled on the request cycle
//   Uart_Busy : frame in progress
//   Uart_Tx   : serial line, idles high
//   Uart_Done : one-cycle pulse at end of stop bit
//   Uart_Ovf  : one-cycle pulse when a request is dropped
interface gpsdo_uart_tx_if;
  logic       Uart_En;
  logic [7:0] Uart_Data;
  logic       Uart_Busy;
  logic       Uart_Tx;
  logic       Uart_Done;
  logic       Uart_Ovf;

  modport master (
    output Uart_En, Uart_Data,
    input  Uart_Busy, Uart_Tx, Uart_Done, Uart_Ovf
  );

  modport slave (
    input  Uart_En, Uart_Data,
    output Uart_Busy, Uart_Tx, Uart_Done, Uart_Ovf
  );
endinterface

// File: rtl/gpsdo_uart_tx.sv
// gpsdo_uart_tx
//   8N1 serial transmitter fed by the phase detector byte interface. One
//   frame is sent per rising edge of Uart_En; a level held high never
//   re-triggers. Requests arriving mid-frame are dropped and flagged.
//   Define UART_TX_PARITY_EN to send 8E1 frames (even parity bit).
// Parameters
//   CLK_FREQ  : system clock frequency in Hz
//   BAUD_RATE : line rate in bit/s
// Ports
//   CLK_SYS : system clock, rising edge
//   CLK_RST : asynchronous active-low reset
//   bus     : gpsdo_uart_tx_if.slave (Uart_En, Uart_Data in;
//             Uart_Busy, Uart_Tx, Uart_Done, Uart_Ovf out, all registered)
module gpsdo_uart_tx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic                   CLK_SYS,
  input  logic                   CLK_RST,
  gpsdo_uart_tx_if.slave         bus
);

  localparam int unsigned BAUD_DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);

  generate
    if (BAUD_DIV < 2) begin : g_bad_div_low
      $error("gpsdo_uart_tx: BAUD_DIV must be at least 2");
    end
    if (BAUD_DIV > 65536) begin : g_bad_div_high
      $error("gpsdo_uart_tx: BAUD_DIV does not fit the 16-bit divider");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state;
  logic        en_d;
  logic [15:0] div_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
`ifdef UART_TX_PARITY_EN
  logic        par_q;
`endif
  logic        tx_q;
  logic        busy_q;
  logic        done_q;
  logic        ovf_q;

  logic        req;
  logic        bit_end;

  always_comb begin
    req     = bus.Uart_En & ~en_d;
    bit_end = (div_cnt == DIV_LAST);
  end

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state   <= IDLE;
      en_d    <= 1'b0;
      div_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      en_d   <= bus.Uart_En;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;

      // The last cycle of the stop bit counts as idle for new requests,
      // so frames can run gapless; every other busy cycle drops them.
      if (req && (state != IDLE) && !((state == STOP) && bit_end))
        ovf_q <= 1'b1;

      if (state == IDLE || bit_end)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (req) begin
            shreg   <= bus.Uart_Data;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^bus.Uart_Data;
`endif
            bit_idx <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state   <= START;
          end
        end

        START: begin
          if (bit_end) begin
            tx_q  <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q  <= par_q;
              state <= PARITY;
`else
              tx_q  <= 1'b1;
              state <= STOP;
`endif
            end else begin
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx_q  <= 1'b1;
            state <= STOP;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            done_q <= 1'b1;
            if (req) begin
              shreg   <= bus.Uart_Data;
`ifdef UART_TX_PARITY_EN
              par_q   <= ^bus.Uart_Data;
`endif
              bit_idx <= '0;
              tx_q    <= 1'b0;
              busy_q  <= 1'b1;
              state   <= START;
            end else begin
              tx_q   <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end

        default: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.Uart_Tx   = tx_q;
  assign bus.Uart_Busy = busy_q;
  assign bus.Uart_Done = done_q;
  assign bus.Uart_Ovf  = ovf_q;

endmodule

// File: tb/tb_gpsdo_uart_tx.sv
module tb_gpsdo_uart_tx;

  localparam int unsigned D = 10;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FRAME = D * NBITS;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  gpsdo_uart_tx_if bus();

  gpsdo_uart_tx #(
    .CLK_FREQ (1_000_000),
    .BAUD_RATE(100_000)
  ) dut (
    .CLK_SYS(clk),
    .CLK_RST(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected line level s cycles after the edge that accepted byte d.
  function automatic logic frame_bit(input logic [7:0] d, input int unsigned s);
    int unsigned b;
    b = s / D;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[3'(b - 1)];
    if (NBITS == 11 && b == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    bus.Uart_En = 1'b0;
    bus.Uart_Data = 8'h00;
    tick; tick;
    vectors++; if (bus.Uart_Tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b expected 1", bus.Uart_Tx); end
    vectors++; if (bus.Uart_Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.Uart_Busy); end
    vectors++; if (bus.Uart_Done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.Uart_Done); end
    vectors++; if (bus.Uart_Ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", bus.Uart_Ovf); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single_frame;
    logic [10:0] mids;
    int busy_cnt, done_cnt;
`ifdef UART_TX_PARITY_EN
    mids = 11'b10010101010;
`else
    mids = 11'b11010101010;
`endif
    busy_cnt = 0; done_cnt = 0;
    bus.Uart_Data = 8'h55;
    bus.Uart_En = 1'b1;
    tick;
    bus.Uart_En = 1'b0;
    for (int unsigned s = 0; s < FRAME + 5; s++) begin
      if (bus.Uart_Busy === 1'b1) busy_cnt++;
      if (bus.Uart_Done === 1'b1) done_cnt++;
      if (s % D == 5 && s < FRAME) begin
        vectors++;
        if (bus.Uart_Tx !== mids[4'(s / D)]) begin
          miscompares++;
          $display("FAIL single_tx_mid s=%0d: got %b expected %b", s, bus.Uart_Tx, mids[4'(s / D)]);
        end
      end
      if (s == FRAME) begin
        vectors++;
        if (bus.Uart_Done !== 1'b1) begin miscompares++; $display("FAIL single_done_at_end: got %b expected 1", bus.Uart_Done); end
      end
      vectors++;
      if (bus.Uart_Ovf !== 1'b0) begin miscompares++; $display("FAIL single_ovf s=%0d: got %b expected 0", s, bus.Uart_Ovf); end
      tick;
    end
    vectors++; if (busy_cnt != FRAME) begin miscompares++; $display("FAIL single_busy_len: got %0d expected %0d", busy_cnt, FRAME); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL single_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_held_level;
    int done_cnt, ovf_cnt, busy_cnt;
    done_cnt = 0; ovf_cnt = 0; busy_cnt = 0;
    bus.Uart_Data = 8'hA3;
    bus.Uart_En = 1'b1;
    tick;
    for (int unsigned s = 0; s < 5000; s++) begin
      if (bus.Uart_Done === 1'b1) done_cnt++;
      if (bus.Uart_Ovf === 1'b1) ovf_cnt++;
      if (bus.Uart_Busy === 1'b1) busy_cnt++;
      if (s % D == 5 && s < FRAME + 30) begin
        vectors++;
        if (bus.Uart_Tx !== frame_bit(8'hA3, s)) begin
          miscompares++;
          $display("FAIL held_tx_mid s=%0d: got %b expected %b", s, bus.Uart_Tx, frame_bit(8'hA3, s));
        end
      end
      if (s == 3) bus.Uart_Data = 8'h5A;
      tick;
    end
    bus.Uart_En = 1'b0;
    tick;
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL held_frames: got %0d expected 1", done_cnt); end
    vectors++; if (ovf_cnt != 0) begin miscompares++; $display("FAIL held_ovf: got %0d expected 0", ovf_cnt); end
    vectors++; if (busy_cnt != FRAME) begin miscompares++; $display("FAIL held_busy_len: got %0d expected %0d", busy_cnt, FRAME); end
  endtask

  task automatic test_overflow;
    int ovf_cnt;
    ovf_cnt = 0;
    bus.Uart_Data = 8'h0F;
    bus.Uart_En = 1'b1;
    tick;
    bus.Uart_En = 1'b0;
    for (int unsigned s = 0; s < FRAME + 30; s++) begin
      if (bus.Uart_Ovf === 1'b1) ovf_cnt++;
      vectors++;
      if (bus.Uart_Tx !== frame_bit(8'h0F, s)) begin
        miscompares++;
        $display("FAIL ovf_tx s=%0d: got %b expected %b", s, bus.Uart_Tx, frame_bit(8'h0F, s));
      end
      vectors++;
      if (bus.Uart_Ovf !== (s == 40)) begin
        miscompares++;
        $display("FAIL ovf_pulse s=%0d: got %b expected %b", s, bus.Uart_Ovf, (s == 40));
      end
      vectors++;
      if (bus.Uart_Busy !== (s < FRAME)) begin
        miscompares++;
        $display("FAIL ovf_busy s=%0d: got %b expected %b", s, bus.Uart_Busy, (s < FRAME));
      end
      if (s == 39) begin bus.Uart_En = 1'b1; bus.Uart_Data = 8'h12; end
      if (s == 40) bus.Uart_En = 1'b0;
      tick;
    end
    vectors++; if (ovf_cnt != 1) begin miscompares++; $display("FAIL ovf_count: got %0d expected 1", ovf_cnt); end
  endtask

  task automatic test_back_to_back;
    logic exp_tx;
    bus.Uart_Data = 8'h00;
    bus.Uart_En = 1'b1;
    tick;
    bus.Uart_En = 1'b0;
    for (int unsigned s = 0; s < 2 * FRAME + 5; s++) begin
      exp_tx = (s < FRAME) ? frame_bit(8'h00, s) : frame_bit(8'hFF, s - FRAME);
      vectors++;
      if (bus.Uart_Tx !== exp_tx) begin
        miscompares++;
        $display("FAIL b2b_tx s=%0d: got %b expected %b", s, bus.Uart_Tx, exp_tx);
      end
      vectors++;
      if (bus.Uart_Busy !== (s < 2 * FRAME)) begin
        miscompares++;
        $display("FAIL b2b_busy s=%0d: got %b expected %b", s, bus.Uart_Busy, (s < 2 * FRAME));
      end
      vectors++;
      if (bus.Uart_Done !== (s == FRAME || s == 2 * FRAME)) begin
        miscompares++;
        $display("FAIL b2b_done s=%0d: got %b expected %b", s, bus.Uart_Done, (s == FRAME || s == 2 * FRAME));
      end
      vectors++;
      if (bus.Uart_Ovf !== 1'b0) begin miscompares++; $display("FAIL b2b_ovf s=%0d: got %b expected 0", s, bus.Uart_Ovf); end
      if (s == FRAME - 1) begin bus.Uart_En = 1'b1; bus.Uart_Data = 8'hFF; end
      if (s == FRAME) bus.Uart_En = 1'b0;
      tick;
    end
  endtask

  task automatic test_reset_mid_frame;
    int done_cnt;
    done_cnt = 0;
    bus.Uart_Data = 8'h3B;
    bus.Uart_En = 1'b1;
    tick;
    bus.Uart_En = 1'b0;
    for (int unsigned s = 0; s < 34; s++) tick;
    // 0x3B bit 2 is 0, so the line is low here
    vectors++; if (bus.Uart_Tx !== 1'b0) begin miscompares++; $display("FAIL rstmid_pre_tx: got %b expected 0", bus.Uart_Tx); end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.Uart_Tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx_async: got %b expected 1", bus.Uart_Tx); end
    vectors++; if (bus.Uart_Busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy_async: got %b expected 0", bus.Uart_Busy); end
    // En already high as reset releases: counts as a fresh request
    bus.Uart_Data = 8'hC5;
    bus.Uart_En = 1'b1;
    tick;
    if (bus.Uart_Done === 1'b1) done_cnt++;
    tick;
    if (bus.Uart_Done === 1'b1) done_cnt++;
    vectors++; if (done_cnt != 0) begin miscompares++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt); end
    rst_n = 1'b1;
    tick;
    bus.Uart_En = 1'b0;
    for (int unsigned s = 0; s < FRAME + 5; s++) begin
      vectors++;
      if (bus.Uart_Tx !== frame_bit(8'hC5, s)) begin
        miscompares++;
        $display("FAIL rstmid_next_tx s=%0d: got %b expected %b", s, bus.Uart_Tx, frame_bit(8'hC5, s));
      end
      vectors++;
      if (bus.Uart_Busy !== (s < FRAME)) begin
        miscompares++;
        $display("FAIL rstmid_next_busy s=%0d: got %b expected %b", s, bus.Uart_Busy, (s < FRAME));
      end
      vectors++;
      if (bus.Uart_Done !== (s == FRAME)) begin
        miscompares++;
        $display("FAIL rstmid_next_done s=%0d: got %b expected %b", s, bus.Uart_Done, (s == FRAME));
      end
      tick;
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [7:0] bytes [2];
    logic       pars  [2];
    int         busy_cnt;
    bytes[0] = 8'h07; pars[0] = 1'b1;
    bytes[1] = 8'h03; pars[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      busy_cnt = 0;
      bus.Uart_Data = bytes[i];
      bus.Uart_En = 1'b1;
      tick;
      bus.Uart_En = 1'b0;
      for (int unsigned s = 0; s < 115; s++) begin
        if (bus.Uart_Busy === 1'b1) busy_cnt++;
        if (s == 95) begin
          vectors++;
          if (bus.Uart_Tx !== pars[i]) begin
            miscompares++;
            $display("FAIL parity_bit data=%h: got %b expected %b", bytes[i], bus.Uart_Tx, pars[i]);
          end
        end
        if (s == 105) begin
          vectors++;
          if (bus.Uart_Tx !== 1'b1) begin miscompares++; $display("FAIL parity_stop data=%h: got %b expected 1", bytes[i], bus.Uart_Tx); end
        end
        if (s == 110) begin
          vectors++;
          if (bus.Uart_Done !== 1'b1) begin miscompares++; $display("FAIL parity_done data=%h: got %b expected 1", bytes[i], bus.Uart_Done); end
        end
        tick;
      end
      vectors++;
      if (busy_cnt != 110) begin miscompares++; $display("FAIL parity_len data=%h: got %0d expected 110", bytes[i], busy_cnt); end
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.Uart_En = 1'b0;
    bus.Uart_Data = 8'h00;
    test_reset;
    test_single_frame;
    test_held_level;
    test_overflow;
    test_back_to_back;
    test_reset_mid_frame;
`ifdef UART_TX_PARITY_EN
    test_parity;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
